// File: rtl/apb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regs
// Brief    : APB register bank with NUM_REGS R/W registers and a read-only
//            write-counter status word. APB_WAIT_EN adds wait states and
//            pready/pslverr ports.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regs #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic                           psel_i,
    input  logic                           penable_i,
    input  logic                           pwrite_i,
    input  logic [ADDR_WIDTH-1:0]          paddr_i,
    input  logic [DATA_WIDTH-1:0]          pwdata_i,
    output logic [DATA_WIDTH-1:0]          prdata_o,
`ifdef APB_WAIT_EN
    output logic                           pready_o,
    output logic                           pslverr_o,
`endif
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o,
    output logic [15:0]                    wr_count_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    pwrite_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    valid_q;
    logic                    status_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic [NUM_REGS-1:0]     wr_pulse_q;
    logic [15:0]             wr_count_q;

    logic [IDX_W-1:0]        w_idx;
    logic                    w_aligned;
    logic                    w_valid;
    logic                    w_status;
    logic                    w_latch;
    logic                    w_to_access;
    logic                    w_commit;
    logic                    w_ready;
    logic                    w_wr_commit;
    logic [NUM_REGS-1:0]     w_onehot;
    logic [DATA_WIDTH-1:0]   w_rdata;

    if (WAIT_CYCLES < 0) begin : g_wait_chk
        $error("WAIT_CYCLES must be non-negative");
    end

    assign w_idx     = paddr_i[ADDR_WIDTH-1:2];
    assign w_aligned = (paddr_i[1:0] == 2'b00);
    assign w_valid   = w_aligned && (w_idx < IDX_W'(NUM_REGS));
    assign w_status  = w_aligned && (w_idx == IDX_W'(NUM_REGS));

    always_comb begin
        state_d     = state_q;
        w_latch     = 1'b0;
        w_to_access = 1'b0;
        w_commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // penable without a preceding setup phase is ignored here
                if (psel_i && !penable_i) begin
                    state_d = ST_SETUP;
                    w_latch = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!psel_i) begin
                    state_d = ST_IDLE;
                end else if (penable_i) begin
                    state_d     = ST_ACCESS;
                    w_to_access = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (psel_i && penable_i && w_ready) begin
                    state_d  = ST_IDLE;
                    w_commit = 1'b1;
                end else if (psel_i && !penable_i) begin
                    state_d = ST_SETUP;
                    w_latch = 1'b1;
                end else if (!psel_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_wr_commit = w_commit && pwrite_q && valid_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        logic [DATA_WIDTH-1:0] data_q;

        assign w_onehot[i] = (idx_q == IDX_W'(i));

        always_ff @(posedge pclk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else if (w_wr_commit && w_onehot[i]) begin
                data_q <= pwdata_i;
            end
        end

        assign reg_out_o[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
    end

    always_comb begin
        w_rdata = '0;
        if (status_q) begin
            w_rdata = DATA_WIDTH'(wr_count_q);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (valid_q && w_onehot[i]) begin
                w_rdata = reg_out_o[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pwrite_q   <= 1'b0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            status_q   <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_pulse_q <= '0;
            if (w_latch) begin
                pwrite_q <= pwrite_i;
                idx_q    <= w_idx;
                valid_q  <= w_valid;
                status_q <= w_status;
            end
            if (w_to_access) begin
                prdata_q <= pwrite_q ? '0 : w_rdata;
            end else if (w_commit) begin
                prdata_q <= '0;
            end
            if (w_wr_commit) begin
                wr_pulse_q <= w_onehot;
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

`ifdef APB_WAIT_EN
    logic [CNT_W-1:0] wait_q;
    logic             w_err;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (w_to_access) begin
            wait_q <= CNT_W'(WAIT_CYCLES);
        end else if ((state_q == ST_ACCESS) && (wait_q != '0)) begin
            wait_q <= wait_q - 1'b1;
        end
    end

    // Status reads are legal; status writes and unmapped addresses are not.
    assign w_err     = !(valid_q || (status_q && !pwrite_q));
    assign w_ready   = (wait_q == '0);
    assign pready_o  = w_ready;
    assign pslverr_o = (state_q == ST_ACCESS) && psel_i && penable_i && w_ready && w_err;
`else
    assign w_ready   = 1'b1;
`endif

    assign prdata_o   = prdata_q;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_count_o = wr_count_q;

endmodule
`default_nettype wire
